// File: rtl/demux32_1x4_reg_if.sv
// Bus bundle for the registered 1-to-4 demultiplexer: upstream word/handshake,
// select controls, the four lane outputs with their handshakes, and the pointer.
interface demux32_1x4_reg_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] IN_DATA;
    logic             IN_VALID;
    logic             IN_READY;
    logic [1:0]       S;
    logic             AUTO;
    logic [WIDTH-1:0] Y0;
    logic [WIDTH-1:0] Y1;
    logic [WIDTH-1:0] Y2;
    logic [WIDTH-1:0] Y3;
    logic             V0;
    logic             V1;
    logic             V2;
    logic             V3;
    logic             R0;
    logic             R1;
    logic             R2;
    logic             R3;
    logic [1:0]       PTR;

    // Demux side: consumes the upstream word and the lane readies.
    modport slave (
        input  IN_DATA, IN_VALID, S, AUTO, R0, R1, R2, R3,
        output IN_READY, Y0, Y1, Y2, Y3, V0, V1, V2, V3, PTR
    );

    // Environment side: drives the upstream word and the lane readies.
    modport master (
        output IN_DATA, IN_VALID, S, AUTO, R0, R1, R2, R3,
        input  IN_READY, Y0, Y1, Y2, Y3, V0, V1, V2, V3, PTR
    );
endinterface

// File: rtl/demux32_1x4_reg.sv
// Registered 1-to-4 demultiplexer. Each lane is a one-word holding register
// with its own valid/ready handshake; the destination is either the manual
// select S or a round-robin pointer that advances on every auto-routed word.
module demux32_1x4_reg #(
    parameter int WIDTH = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    demux32_1x4_reg_if.slave       bus
);
    logic [WIDTH-1:0] r_y [4];
    logic [3:0]       r_v;
    logic [1:0]       r_ptr;

    logic [3:0]       w_rdy;
    logic [1:0]       w_dest;
    logic             w_in_ready;
    logic             w_xfer;
    logic [3:0]       w_load;

    // Destination decode and upstream handshake; select changes act immediately.
    always_comb begin
        w_rdy      = {bus.R3, bus.R2, bus.R1, bus.R0};
        w_dest     = bus.AUTO ? r_ptr : bus.S;
        // A full lane may still accept when it drains on the same edge.
        w_in_ready = ~RST & (~r_v[w_dest] | w_rdy[w_dest]);
        w_xfer     = bus.IN_VALID & w_in_ready;
        w_load     = w_xfer ? (4'b0001 << w_dest) : 4'b0000;
    end

    // Lane registers and round-robin pointer; reset discards all held words.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_v   <= '0;
            r_ptr <= '0;
            for (int k = 0; k < 4; k++) begin
                r_y[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_load[k]) begin
                    r_y[k] <= bus.IN_DATA;
                    r_v[k] <= 1'b1;
                end else if (r_v[k] && w_rdy[k]) begin
                    r_v[k] <= 1'b0;
                end
            end
            if (w_xfer && bus.AUTO) begin
                r_ptr <= r_ptr + 2'd1;
            end
        end
    end

    assign bus.IN_READY = w_in_ready;
    assign bus.Y0       = r_y[0];
    assign bus.Y1       = r_y[1];
    assign bus.Y2       = r_y[2];
    assign bus.Y3       = r_y[3];
    assign bus.V0       = r_v[0];
    assign bus.V1       = r_v[1];
    assign bus.V2       = r_v[2];
    assign bus.V3       = r_v[3];
    assign bus.PTR      = r_ptr;
endmodule

// File: doc/demux32_1x4_reg.md
DEMUX32_1X4_REG -- requirements
Module: demux32_1x4_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset; one clock, reset is asynchronous and active-high.
REQ-004 SHALL have port IN_DATA  input  WIDTH  word offered by upstream.
REQ-005 SHALL have port IN_VALID  input  1  upstream word present.
REQ-006 SHALL have port IN_READY  output  1  block accepts word this cycle.
REQ-007 SHALL have port S  input  2  destination select when AUTO=0.
REQ-008 SHALL have port AUTO  input  1  1 = round-robin destination from PTR, S ignored.
REQ-009 SHALL have ports Y0..Y3  output  WIDTH each  per-lane holding registers.
REQ-010 SHALL have ports V0..V3  output  1 each  per-lane valid.
REQ-011 SHALL have ports R0..R3  input  1 each  per-lane downstream ready.
REQ-012 SHALL have port PTR  output  2  round-robin pointer.

Function
REQ-013 SHALL compute destination d = AUTO ? PTR : S, combinationally, every cycle.
REQ-014 SHALL drive IN_READY = ~RST & (~Vd | Rd), combinational from lane state and Rd.
REQ-015 SHALL accept a word when IN_VALID & IN_READY at a rising edge: Yd <= IN_DATA, Vd <= 1.
REQ-016 SHALL present accepted data one cycle later: transfer at edge N -> Yd, Vd=1 visible after edge N.
REQ-017 SHALL clear Vk at an edge where Vk & Rk and lane k is not loaded in the same cycle.
REQ-018 SHALL keep Vk=1 and load new data when lane k drains and is loaded in the same cycle (no bubble).
REQ-019 SHALL hold Yk and Vk unchanged while Vk=1 and Rk=0 (no overwrite, no drop).
REQ-020 SHALL retain Yk after drain; Yk changes only on load into lane k.
REQ-021 SHALL stall upstream (IN_READY=0) when the destination lane is full and not draining; other lanes continue draining independently.
REQ-022 SHALL increment PTR by 1 modulo 4 (3 -> 0 wrap) on each accepted transfer while AUTO=1.
REQ-023 SHALL hold PTR while AUTO=0 or when no transfer occurs; AUTO toggling SHALL neither reset nor advance PTR.
REQ-024 SHALL apply an AUTO or S change in the same cycle it occurs (no pipeline on select).
REQ-025 SHALL ignore S entirely while AUTO=1 and ignore PTR for routing while AUTO=0.
REQ-026 SHALL route at most one word per cycle; lanes other than d SHALL never be loaded.
REQ-027 SHALL NOT require upstream to hold IN_DATA/S stable while stalled; routing uses values present at the accepting edge.

Reset
REQ-028 SHALL, on RST assertion, immediately and asynchronously clear V0..V3=0, Y0..Y3=0, PTR=0.
REQ-029 SHALL hold IN_READY=0 for the whole time RST is high; no transfer while RST high.
REQ-030 SHALL discard all held words on reset mid-operation; no partial or late update after RST rises.
REQ-031 SHALL resume normal operation on the first rising CLK edge after RST deasserts, IN_READY=1 for any d.

Verification
REQ-032 Directed: AUTO=0, S=2, IN_DATA=0xDEADBEEF, IN_VALID 1 cycle, R2=0 -> Y2=0xDEADBEEF, V2=1 next cycle, held; other V=0.
REQ-033 Directed: AUTO=1, PTR=0, four words 0x1..0x4 back-to-back, all R=1 -> Y0..Y3=0x1..0x4 in order, PTR wraps 3->0, no stall.
REQ-034 Directed: AUTO=0, S=1, V1=1, R1=0, IN_VALID=1 -> IN_READY=0, Y1 unchanged; raise R1 -> new word loaded same edge, V1 stays 1.
REQ-035 Directed: V3=1, R3=1, S=3, IN_VALID=1, IN_DATA=0xA5A5A5A5 -> Y3=0xA5A5A5A5, V3=1 (drain+load, no bubble).
REQ-036 Directed: AUTO=1, PTR=2, two transfers, switch AUTO=0 with S=0, one transfer, switch AUTO=1 -> PTR=0 after the two transfers, still 0 after manual transfer, next auto word goes to lane 0.
REQ-037 Directed: lanes 0,2 valid with R=0, assert RST mid-cycle (between edges) -> V0=V2=0, Y=0, PTR=0, IN_READY=0 immediately; release -> IN_READY=1.
